keyboard_fifo_reader: RTL and testbench

Parametrised successor to the single-code keyboard reader. It buffers every new key event (make/break) in a DEPTH-entry FIFO, so scan codes are not lost between READKEY instructions. On a READKEY instruction it pops, peeks, reports status or flushes the buffer, and returns the result as a one-cycle register-file writeback (enable/addr/data). It sits beside the other I/O writeback sources feeding the integer register file.

---
 rtl/keyboard_fifo_reader_pkg.sv | 17 +
 rtl/keyboard_fifo_reader_fifo.sv | 57 +++++
 rtl/keyboard_fifo_reader.sv | 110 +++++++++++
 tb/tb_keyboard_fifo_reader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/keyboard_fifo_reader_pkg.sv
// Shared constants for the buffered keyboard reader.
// Optional feature macro: KEYBOARD_BREAK_FILTER_EN (see keyboard_fifo_reader.sv).
package keyboard_fifo_reader_pkg;

    localparam logic [5:0] READKEY = 6'b011111;

    typedef enum logic [1:0] {
        FN_POP    = 2'd0,
        FN_PEEK   = 2'd1,
        FN_STATUS = 2'd2,
        FN_CLEAR  = 2'd3
    } kbd_func_e;

    localparam int VALID_BIT = 31;
    localparam int OVF_BIT   = 31;

endpackage

// File: rtl/keyboard_fifo_reader_fifo.sv
// DEPTH-entry key event FIFO with push/pop/flush and occupancy count.
// Full/empty are derived from count; pointers wrap naturally.
module kbd_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 9,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             dropped
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty && !flush;
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign push_ok = push && !flush && (!full || pop_ok);
    assign dropped = push && !flush && !push_ok;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok) count <= count + 1'b1;
            else if (pop_ok && !push_ok) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/keyboard_fifo_reader.sv
// Buffered keyboard reader: READKEY pop/peek/status/clear with registered writeback.
// Define KEYBOARD_BREAK_FILTER_EN to drop release events before the FIFO.
module keyboard_fifo_reader
    import keyboard_fifo_reader_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int CODE_W = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       inst,
    input  logic              key_push,
    input  logic              key_break,
    input  logic [CODE_W-1:0] keycode,
    output logic              enable,
    output logic              float,
    output logic [4:0]        addr,
    output logic [31:0]       data,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);
    logic            cmd;
    kbd_func_e       func;
    logic [4:0]      rt;
    logic            push_q;
    logic            pop;
    logic            clear;
    logic            empty;
    logic            dropped;
    logic [CODE_W:0] head;
    logic [CODE_W:0] head_q;
    logic [31:0]     rd_data;
    logic            unused;

    assign cmd   = (inst[31:26] == READKEY);
    assign func  = kbd_func_e'(inst[1:0]);
    assign rt    = inst[20:16];
    assign pop   = cmd && (func == FN_POP);
    assign clear = cmd && (func == FN_CLEAR);
    assign float = 1'b0;

`ifdef KEYBOARD_BREAK_FILTER_EN
    assign push_q = key_push && !key_break;
    assign head_q = {1'b0, head[CODE_W-1:0]};
    assign unused = ^{inst[25:21], inst[15:2], head[CODE_W]};
`else
    assign push_q = key_push;
    assign head_q = head;
    assign unused = ^{inst[25:21], inst[15:2]};
`endif

    kbd_fifo #(
        .DEPTH (DEPTH),
        .W     (CODE_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_q),
        .pop     (pop),
        .flush   (clear),
        .din     ({key_break, keycode}),
        .head    (head),
        .count   (count),
        .empty   (empty),
        .dropped (dropped)
    );

    always_comb begin
        rd_data = '0;
        case (func)
            FN_POP, FN_PEEK: begin
                if (!empty) begin
                    rd_data[VALID_BIT] = 1'b1;
                    rd_data[CODE_W:0]  = head_q;
                end
            end
            FN_STATUS: begin
                rd_data[OVF_BIT]   = overflow;
                rd_data[CNT_W-1:0] = count;
            end
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
        end else if (dropped) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable <= 1'b0;
            addr   <= '0;
            data   <= '0;
        end else begin
            enable <= cmd;
            if (cmd) begin
                addr <= rt;
                data <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_keyboard_fifo_reader.sv
// Self-checking bench for keyboard_fifo_reader against a queue-based model.
// Default parameters: DEPTH=16, CODE_W=8.
module tb_keyboard_fifo_reader;
    import keyboard_fifo_reader_pkg::*;

    localparam int DEPTH  = 16;
    localparam int CODE_W = 8;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       inst = '0;
    logic              key_push = 1'b0;
    logic              key_break = 1'b0;
    logic [CODE_W-1:0] keycode = '0;
    logic              enable;
    logic              float;
    logic [4:0]        addr;
    logic [31:0]       data;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    int n_checks = 0;
    int n_pass = 0;

    int   q[$];
    bit   m_ovf;
    bit   e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    int   e_cnt;

    always #5 clk = ~clk;

    keyboard_fifo_reader #(.DEPTH(DEPTH), .CODE_W(CODE_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inst      (inst),
        .key_push  (key_push),
        .key_break (key_break),
        .keycode   (keycode),
        .enable    (enable),
        .float     (float),
        .addr      (addr),
        .data      (data),
        .count     (count),
        .overflow  (overflow)
    );

    task automatic model_reset();
        q.delete();
        m_ovf  = 0;
        e_en   = 0;
        e_addr = '0;
        e_data = '0;
        e_cnt  = 0;
    endtask

    // Drive one cycle of stimulus, advance the model, and wait past the edge.
    task automatic step(input bit c, input int f, input int r,
                        input bit p, input bit b, input int k);
        bit   pa;
        bit   popped;
        logic [5:0] op;
        op = READKEY;
        if (!c) op = READKEY ^ 6'($urandom_range(1, 63));
        inst = {op, 5'($urandom), 5'(r), 14'($urandom), 2'(f)};
        key_push  = p;
        key_break = b;
        keycode   = CODE_W'(k);
        e_en = c;
        if (c) begin
            e_addr = 5'(r);
            case (f)
                0, 1: e_data = (q.size() > 0) ? (32'h8000_0000 | 32'(q[0])) : 32'h0;
                2: e_data = (m_ovf ? 32'h8000_0000 : 32'h0) | 32'(q.size());
                default: e_data = 32'h0;
            endcase
        end
        pa = p;
`ifdef KEYBOARD_BREAK_FILTER_EN
        pa = p && !b;
`endif
        if (c && f == 3) begin
            q.delete();
            m_ovf = 0;
        end else begin
            popped = c && f == 0 && q.size() > 0;
            if (popped) void'(q.pop_front());
            if (pa) begin
                if (q.size() < DEPTH) q.push_back((int'(b) << CODE_W) | (k & 255));
                else m_ovf = 1;
            end
        end
        e_cnt = q.size();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        n_checks++; if (enable !== 1'b0) $display("FAIL reset_en actual=%b required=0", enable); else n_pass++;
        n_checks++; if (addr !== 5'd0) $display("FAIL reset_addr actual=%0d required=0", addr); else n_pass++;
        n_checks++; if (data !== 32'd0) $display("FAIL reset_data actual=%h required=0", data); else n_pass++;
        n_checks++; if (count !== '0) $display("FAIL reset_count actual=%0d required=0", count); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf actual=%b required=0", overflow); else n_pass++;
        n_checks++; if (float !== 1'b0) $display("FAIL reset_float actual=%b required=0", float); else n_pass++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_pop_empty();
        step(1, 0, 5, 0, 0, 0);
        n_checks++; if (enable !== 1'b1) $display("FAIL pe_en actual=%b required=1", enable); else n_pass++;
        n_checks++; if (addr !== 5'd5) $display("FAIL pe_addr actual=%0d required=5", addr); else n_pass++;
        n_checks++; if (data !== 32'h0) $display("FAIL pe_data actual=%h required=0", data); else n_pass++;
        n_checks++; if (count !== 0) $display("FAIL pe_count actual=%0d required=0", count); else n_pass++;
        idle();
        n_checks++; if (enable !== 1'b0) $display("FAIL pe_idle_en actual=%b required=0", enable); else n_pass++;
    endtask

    task automatic test_make_break();
        step(0, 0, 0, 1, 0, 'h1C);
        step(0, 0, 0, 1, 1, 'h1C);
        n_checks++; if (count !== 2) $display("FAIL mb_count actual=%0d required=2", count); else n_pass++;
        step(1, 0, 3, 0, 0, 0);
        n_checks++; if (data !== e_data || addr !== 5'd3) $display("FAIL mb_pop1 actual=%h/%0d required=%h/3", data, addr, e_data); else n_pass++;
        step(1, 0, 3, 0, 0, 0);
        n_checks++; if (data !== e_data) $display("FAIL mb_pop2 actual=%h required=%h", data, e_data); else n_pass++;
        n_checks++; if (count !== 0) $display("FAIL mb_count_end actual=%0d required=0", count); else n_pass++;
        idle();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH + 1; i++)
            step(0, 0, 0, 1, $urandom_range(0, 1), $urandom_range(0, 255));
        n_checks++; if (count !== CNT_W'(e_cnt)) $display("FAIL of_count actual=%0d required=%0d", count, e_cnt); else n_pass++;
        n_checks++; if (overflow !== m_ovf) $display("FAIL of_ovf actual=%b required=%b", overflow, m_ovf); else n_pass++;
        step(1, 2, 7, 0, 0, 0);
        n_checks++; if (data !== e_data) $display("FAIL of_status actual=%h required=%h", data, e_data); else n_pass++;
        for (int i = 0; i < DEPTH + 1; i++) begin
            step(1, 0, i, 0, 0, 0);
            n_checks++; if (data !== e_data) $display("FAIL of_pop%0d actual=%h required=%h", i, data, e_data); else n_pass++;
        end
        n_checks++; if (count !== 0) $display("FAIL of_count_end actual=%0d required=0", count); else n_pass++;
    endtask

    task automatic test_full_push_pop();
        step(1, 3, 1, 0, 0, 0);
        n_checks++; if (overflow !== 1'b0) $display("FAIL fp_clr_ovf actual=%b required=0", overflow); else n_pass++;
        for (int i = 0; i < DEPTH; i++)
            step(0, 0, 0, 1, 0, $urandom_range(0, 255));
        step(1, 0, 2, 1, 0, 'h2A);
        n_checks++; if (data !== e_data) $display("FAIL fp_pop actual=%h required=%h", data, e_data); else n_pass++;
        n_checks++; if (count !== CNT_W'(DEPTH)) $display("FAIL fp_count actual=%0d required=%0d", count, DEPTH); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL fp_ovf actual=%b required=0", overflow); else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, 4, 0, 0, 0);
            n_checks++; if (data !== e_data) $display("FAIL fp_drain%0d actual=%h required=%h", i, data, e_data); else n_pass++;
        end
        n_checks++; if (data !== 32'h8000_002A) $display("FAIL fp_last actual=%h required=8000002a", data); else n_pass++;
    endtask

    task automatic test_peek_clear();
        logic [31:0] first;
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 1, $urandom_range(0, 1), $urandom_range(0, 255));
        step(1, 1, 9, 0, 0, 0);
        first = data;
        n_checks++; if (data !== e_data) $display("FAIL pc_peek1 actual=%h required=%h", data, e_data); else n_pass++;
        step(1, 1, 9, 0, 0, 0);
        n_checks++; if (data !== first) $display("FAIL pc_peek2 actual=%h required=%h", data, first); else n_pass++;
        step(1, 3, 10, 1, 0, 'h55);
        n_checks++; if (enable !== 1'b1 || data !== 32'h0) $display("FAIL pc_clear actual=%b/%h required=1/0", enable, data); else n_pass++;
        n_checks++; if (count !== 0 || overflow !== 1'b0) $display("FAIL pc_state actual=%0d/%b required=0/0", count, overflow); else n_pass++;
        step(1, 0, 11, 0, 0, 0);
        n_checks++; if (data !== 32'h0) $display("FAIL pc_pop actual=%h required=0", data); else n_pass++;
    endtask

    task automatic test_random();
        bit c;
        int f;
        for (int i = 0; i < 400; i++) begin
            c = ($urandom_range(0, 99) < 40);
            f = ($urandom_range(0, 19) == 0) ? 3 : $urandom_range(0, 2);
            step(c, f, $urandom_range(0, 31), ($urandom_range(0, 99) < 60),
                 $urandom_range(0, 1), $urandom_range(0, 255));
            n_checks++;
            if (enable !== e_en || (e_en && (addr !== e_addr || data !== e_data))
                || count !== CNT_W'(e_cnt) || overflow !== m_ovf) begin
                $display("FAIL rand%0d actual=%b/%0d/%h/%0d/%b required=%b/%0d/%h/%0d/%b",
                         i, enable, addr, data, count, overflow,
                         e_en, e_addr, e_data, e_cnt, m_ovf);
            end else n_pass++;
        end
        idle();
    endtask

    task automatic test_async_reset();
        step(0, 0, 0, 1, 0, 'h33);
        step(1, 0, 6, 0, 0, 0);
        n_checks++; if (enable !== 1'b1) $display("FAIL ar_pre_en actual=%b required=1", enable); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (enable !== 1'b0 || data !== 32'h0) $display("FAIL ar_en actual=%b/%h required=0/0", enable, data); else n_pass++;
        n_checks++; if (count !== 0) $display("FAIL ar_count actual=%0d required=0", count); else n_pass++;
        inst = '0;
        key_push = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
        idle();
        n_checks++; if (enable !== 1'b0 || count !== 0) $display("FAIL ar_after actual=%b/%0d required=0/0", enable, count); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_pop_empty();
        test_make_break();
        test_overflow();
        test_full_push_pop();
        test_peek_clear();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
